// File: rtl/mag_minmax_tracker.sv
// Windowed max/min tracker: reports max, min and max-occurrence count
// once every WINDOW accepted unsigned samples.
module mag_minmax_tracker #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned WINDOW = 8,
  localparam int unsigned CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             win_valid,
  output logic [WIDTH-1:0] win_max,
  output logic [WIDTH-1:0] win_min,
  output logic [CNT_W-1:0] win_max_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccum  = 2'd1;
  localparam logic [1:0] StReport = 2'd2;

  localparam logic [CNT_W-1:0] WinLast = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [WIDTH-1:0] win_max_q, win_max_d;
  logic [WIDTH-1:0] win_min_q, win_min_d;
  logic [CNT_W-1:0] win_max_cnt_q, win_max_cnt_d;

  logic             accept;
  logic             first;
  logic [WIDTH-1:0] upd_max, upd_min;
  logic [CNT_W-1:0] upd_cnt, upd_n;

  assign in_ready    = (state_q != StReport) && !clear;
  assign accept      = in_valid && in_ready;
  assign win_valid   = (state_q == StReport);
  assign win_max     = win_max_q;
  assign win_min     = win_min_q;
  assign win_max_cnt = win_max_cnt_q;

  // Running values as they would be after accepting in_data; the first sample
  // of a window seeds everything regardless of the stale run_* contents.
  always_comb begin
    first   = (state_q == StIdle);
    upd_max = run_max_q;
    upd_cnt = max_cnt_q;
    if (first || (in_data > run_max_q)) begin
      upd_max = in_data;
      upd_cnt = CntOne;
    end else if (in_data == run_max_q) begin
      upd_cnt = max_cnt_q + CntOne;
    end
    upd_min = (first || (in_data < run_min_q)) ? in_data : run_min_q;
    upd_n   = first ? CntOne : (n_q + CntOne);
  end

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    max_cnt_d     = max_cnt_q;
    run_max_d     = run_max_q;
    run_min_d     = run_min_q;
    win_max_d     = win_max_q;
    win_min_d     = win_min_q;
    win_max_cnt_d = win_max_cnt_q;

    if (clear) begin
      state_d   = StIdle;
      n_d       = '0;
      max_cnt_d = '0;
      run_max_d = '0;
      run_min_d = '0;
    end else begin
      case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            n_d       = upd_n;
            max_cnt_d = upd_cnt;
            run_max_d = upd_max;
            run_min_d = upd_min;
            if (upd_n == WinLast) begin
              state_d       = StReport;
              win_max_d     = upd_max;
              win_min_d     = upd_min;
              win_max_cnt_d = upd_cnt;
            end else begin
              state_d = StAccum;
            end
          end
        end
        StReport: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      n_q           <= '0;
      max_cnt_q     <= '0;
      run_max_q     <= '0;
      run_min_q     <= '0;
      win_max_q     <= '0;
      win_min_q     <= '0;
      win_max_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      max_cnt_q     <= max_cnt_d;
      run_max_q     <= run_max_d;
      run_min_q     <= run_min_d;
      win_max_q     <= win_max_d;
      win_min_q     <= win_min_d;
      win_max_cnt_q <= win_max_cnt_d;
    end
  end

endmodule

// File: tb/tb_mag_minmax_tracker.sv
// Bench for mag_minmax_tracker: directed scenarios plus random traffic checked
// against a queue-based window model.
module tb_mag_minmax_tracker;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned WINDOW = 8;
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             win_valid;
  logic [WIDTH-1:0] win_max;
  logic [WIDTH-1:0] win_min;
  logic [CNT_W-1:0] win_max_cnt;

  mag_minmax_tracker #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .clear       (clear),
    .win_valid   (win_valid),
    .win_max     (win_max),
    .win_min     (win_min),
    .win_max_cnt (win_max_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned pulses;

  // Reference model: samples of the open window, pending report flag, last result.
  int unsigned win_q[$];
  bit          report_now;
  int unsigned exp_max;
  int unsigned exp_min;
  int unsigned exp_cnt;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_report();
    int unsigned mx;
    int unsigned mn;
    int unsigned cnt;
    mx  = 0;
    mn  = (1 << WIDTH) - 1;
    cnt = 0;
    foreach (win_q[i]) begin
      if (win_q[i] > mx) mx = win_q[i];
      if (win_q[i] < mn) mn = win_q[i];
    end
    foreach (win_q[i]) if (win_q[i] == mx) cnt++;
    exp_max = mx;
    exp_min = mn;
    exp_cnt = cnt;
  endtask

  // One clock cycle: entered and left at the falling edge.
  task automatic cycle(input bit v, input int unsigned d, input bit c, input bit r,
                       output bit acc);
    bit exp_ready;
    in_valid = v;
    in_data  = d[WIDTH-1:0];
    clear    = c;
    rst      = r;
    #1;
    exp_ready = !report_now && !c;
    check_eq("in_ready", in_ready, exp_ready);
    acc = v && exp_ready && !r;
    @(posedge clk);
    if (r) begin
      win_q.delete();
      report_now = 1'b0;
      exp_max    = 0;
      exp_min    = 0;
      exp_cnt    = 0;
    end else if (c) begin
      win_q.delete();
      report_now = 1'b0;
    end else if (report_now) begin
      report_now = 1'b0;
    end else if (acc) begin
      win_q.push_back(d % (1 << WIDTH));
      if (win_q.size() == WINDOW) begin
        model_report();
        report_now = 1'b1;
        win_q.delete();
      end
    end
    @(negedge clk);
    check_eq("win_valid", win_valid, report_now);
    check_eq("win_max", win_max, exp_max);
    check_eq("win_min", win_min, exp_min);
    check_eq("win_max_cnt", win_max_cnt, exp_cnt);
    if (win_valid) pulses++;
  endtask

  initial begin
    int unsigned seq2[8];
    int unsigned accepted;
    bit          acc;

    n_checks   = 0;
    n_errors   = 0;
    pulses     = 0;
    report_now = 1'b0;
    exp_max    = 0;
    exp_min    = 0;
    exp_cnt    = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    clear      = 1'b0;

    // Power-on reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_win_valid", win_valid, 0);
    check_eq("rst_win_max", win_max, 0);
    check_eq("rst_win_min", win_min, 0);
    check_eq("rst_win_max_cnt", win_max_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Back-to-back window.
    seq2 = '{3, 5, 1, 5, 7, 0, 7, 2};
    foreach (seq2[i]) cycle(1'b1, seq2[i], 1'b0, 1'b0, acc);
    check_eq("t2_win_valid", win_valid, 1);
    check_eq("t2_in_ready", in_ready, 0);
    check_eq("t2_win_max", win_max, 7);
    check_eq("t2_win_min", win_min, 0);
    check_eq("t2_win_max_cnt", win_max_cnt, 2);
    cycle(1'b0, 0, 1'b0, 1'b0, acc);
    check_eq("t2_after_valid", win_valid, 0);
    check_eq("t2_after_ready", in_ready, 1);

    // All-equal samples with random gaps.
    pulses   = 0;
    accepted = 0;
    for (int i = 0; i < 200 && accepted < WINDOW; i++) begin
      cycle(($urandom_range(0, 2) != 0), 4, 1'b0, 1'b0, acc);
      if (acc) accepted++;
    end
    check_eq("t3_accepts", accepted, WINDOW);
    cycle(1'b0, 0, 1'b0, 1'b0, acc);
    check_eq("t3_pulses", pulses, 1);
    check_eq("t3_win_max", win_max, 4);
    check_eq("t3_win_min", win_min, 4);
    check_eq("t3_win_max_cnt", win_max_cnt, 8);

    // Partial window aborted by clear.
    pulses = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom_range(0, 7), 1'b0, 1'b0, acc);
    cycle(1'b1, 7, 1'b1, 1'b0, acc);
    for (int i = 0; i < 8; i++) cycle(1'b1, (i % 2 == 0) ? 6 : 1, 1'b0, 1'b0, acc);
    check_eq("t4_pulses", pulses, 1);
    check_eq("t4_win_max", win_max, 6);
    check_eq("t4_win_min", win_min, 1);
    check_eq("t4_win_max_cnt", win_max_cnt, 4);

    // in_valid held across REPORT: stalls one cycle, then starts the next window.
    cycle(1'b1, 7, 1'b0, 1'b0, acc);
    check_eq("t5_stall", acc, 0);
    cycle(1'b1, 7, 1'b0, 1'b0, acc);
    check_eq("t5_accept", acc, 1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 2, 1'b0, 1'b0, acc);
    check_eq("t5_win_max", win_max, 7);
    check_eq("t5_win_max_cnt", win_max_cnt, 1);
    cycle(1'b0, 0, 1'b0, 1'b0, acc);

    // Reset mid-window, then a window of zeros.
    for (int i = 0; i < 6; i++) cycle(1'b1, $urandom_range(0, 7), 1'b0, 1'b0, acc);
    cycle(1'b1, 5, 1'b0, 1'b1, acc);
    check_eq("t6_rst_win_max", win_max, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 0, 1'b0, 1'b0, acc);
    cycle(1'b0, 0, 1'b0, 1'b0, acc);
    check_eq("t6_pulses", pulses, 1);
    check_eq("t6_win_max", win_max, 0);
    check_eq("t6_win_min", win_min, 0);
    check_eq("t6_win_max_cnt", win_max_cnt, 8);

    // Random traffic, biased toward the extreme values.
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      int unsigned d;
      sel = $urandom_range(0, 3);
      d   = (sel == 0) ? 0 : (sel == 1) ? 7 : $urandom_range(0, 7);
      cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 299) == 0), acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
